// File: rtl/hps_sha_dma_pkg.sv
// Shared types and constants for the SHA-256 message-RAM DMA master.
// Optional writeback path is selected by HPS_SHA_DMA_WB_EN (see hps_sha_dma.sv).
package hps_sha_dma_pkg;

    localparam int WORDS_PER_BLK = 4;
    localparam int BLK_W         = 512;
    localparam int WORD_W        = 128;
    localparam int DIG_W         = 256;

    localparam logic [15:0] BE_ALL = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_DRAIN,
        S_OFFER,
        S_WAITD,
        S_WR0,
        S_WR1,
        S_FIN
    } state_t;

endpackage

// File: rtl/hps_sha_blk_asm.sv
// Four-word capture register; word k lands in the k-th most significant
// 128-bit slot of blk_data and holds until overwritten or reset.
module hps_sha_blk_asm
    import hps_sha_dma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [1:0]        load_idx,
    input  logic [WORD_W-1:0] load_word,
    output logic [BLK_W-1:0]  blk_data
);

    logic [WORD_W-1:0] words [WORDS_PER_BLK];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < WORDS_PER_BLK; k++) begin
                words[k] <= '0;
            end
        end else if (load_en) begin
            words[load_idx] <= load_word;
        end
    end

    always_comb begin
        blk_data = '0;
        for (int k = 0; k < WORDS_PER_BLK; k++) begin
            blk_data[BLK_W-1-WORD_W*k -: WORD_W] = words[k];
        end
    end

endmodule

// File: rtl/hps_sha_dma.sv
// Avalon-MM master: streams 512-bit blocks from the message RAM to the SHA core.
// Define HPS_SHA_DMA_WB_EN to compile in the digest writeback (WAITD/WR0/WR1).
module hps_sha_dma
    import hps_sha_dma_pkg::*;
#(
    parameter int AW  = 10,
    parameter int NBW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     src_addr,
    input  logic [AW-1:0]     dst_addr,
    input  logic [NBW-1:0]    num_blocks,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     address,
    output logic              chipselect,
    output logic              write,
    output logic [15:0]       byteenable,
    output logic [WORD_W-1:0] writedata,
    input  logic [WORD_W-1:0] readdata,
    output logic [BLK_W-1:0]  blk_data,
    output logic              blk_valid,
    output logic              blk_first,
    input  logic              blk_ready,
    input  logic [DIG_W-1:0]  digest,
    input  logic              digest_valid,
    output state_t            dbg_state
);

    // Block handshake: blk_valid is high only in OFFER and blk_data is frozen
    // while it is high; the block transfers on the edge where blk_ready is also high.

`ifdef HPS_SHA_DMA_WB_EN
    localparam state_t S_AFTER_LAST = S_WAITD;
    logic [AW-1:0]    dst_q;
    logic [DIG_W-1:0] digest_q;
`else
    localparam state_t S_AFTER_LAST = S_FIN;
    logic unused_wb;
    assign unused_wb = ^{digest, digest_valid, dst_addr};
`endif

    state_t         state, state_n;
    logic [AW-1:0]  rd_ptr;
    logic [NBW-1:0] blk_left;
    logic [1:0]     rd_cnt;
    logic           first_q;
    logic           cap_en;
    logic [1:0]     cap_idx;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        case (state)
            S_IDLE:  if (start) state_n = (num_blocks == '0) ? S_FIN : S_RD;
            S_RD: begin
                chipselect = 1'b1;
                address    = rd_ptr;
                if (rd_cnt == 2'd3) state_n = S_DRAIN;
            end
            S_DRAIN: state_n = S_OFFER;
            S_OFFER: if (blk_ready) state_n = (blk_left == NBW'(1)) ? S_AFTER_LAST : S_RD;
`ifdef HPS_SHA_DMA_WB_EN
            S_WAITD: if (digest_valid) state_n = S_WR0;
            S_WR0: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = dst_q;
                writedata  = digest_q[DIG_W-1 -: WORD_W];
                state_n    = S_WR1;
            end
            S_WR1: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = dst_q + AW'(1);
                writedata  = digest_q[WORD_W-1:0];
                state_n    = S_FIN;
            end
`endif
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Read data returns one cycle after issue, so capture lags the read by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            blk_left <= '0;
            rd_cnt   <= '0;
            first_q  <= 1'b0;
            cap_en   <= 1'b0;
            cap_idx  <= '0;
`ifdef HPS_SHA_DMA_WB_EN
            dst_q    <= '0;
            digest_q <= '0;
`endif
        end else begin
            cap_en  <= (state == S_RD);
            cap_idx <= rd_cnt;
            case (state)
                S_IDLE: if (start) begin
                    rd_ptr   <= src_addr;
                    blk_left <= num_blocks;
                    rd_cnt   <= '0;
                    first_q  <= 1'b1;
`ifdef HPS_SHA_DMA_WB_EN
                    dst_q    <= dst_addr;
`endif
                end
                S_RD: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    rd_cnt <= rd_cnt + 2'd1;
                end
                S_OFFER: if (blk_ready) begin
                    blk_left <= blk_left - NBW'(1);
                    first_q  <= 1'b0;
                end
`ifdef HPS_SHA_DMA_WB_EN
                S_WAITD: if (digest_valid) digest_q <= digest;
`endif
                default: ;
            endcase
        end
    end

    hps_sha_blk_asm u_asm (
        .clk       (clk),
        .reset     (reset),
        .load_en   (cap_en),
        .load_idx  (cap_idx),
        .load_word (readdata),
        .blk_data  (blk_data)
    );

    assign busy       = (state != S_IDLE) && (state != S_FIN);
    assign done       = (state == S_FIN);
    assign blk_valid  = (state == S_OFFER);
    assign blk_first  = blk_valid & first_q;
    assign byteenable = chipselect ? BE_ALL : 16'h0000;
    assign dbg_state  = state;

endmodule
